// File: rtl/gt_link_pkg.sv
// rtl/gt_link_pkg.sv - shared types and constants for the GT link bring-up monitor
package gt_link_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic [2:0] {
        RESET_GT  = 3'd0,
        WAIT_GOOD = 3'd1,
        DEBOUNCE  = 3'd2,
        UP        = 3'd3,
        FAIL      = 3'd4
    } gt_link_state_t;

endpackage

// File: rtl/gt_link_monitor.sv
// rtl/gt_link_monitor.sv - GT reset sequencing, all-good debounce, retry and drop accounting
module gt_link_monitor
    import gt_link_pkg::*;
#(
    parameter int N_CHANNEL          = 1,
    parameter int RESET_PULSE_CYCLES = 256,
    parameter int TIMEOUT_CYCLES     = 1 << 20,
    parameter int DEBOUNCE_CYCLES    = 1024,
    parameter int MAX_RETRY          = 8
) (
    input  logic                          init_clk,
    input  logic                          rst,
    input  logic                          tx_good_init_synced,
    input  logic [N_CHANNEL-1:0]          rx_good_init_synced,
    output logic                          gt_reset,
    output logic                          link_up,
    output logic                          link_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic [DROP_CNT_W-1:0]         drop_cnt
);

    // One timer serves all three timed states, so size it for the longest interval.
    localparam int MAX_CYCLES = (RESET_PULSE_CYCLES > TIMEOUT_CYCLES) ?
        ((RESET_PULSE_CYCLES > DEBOUNCE_CYCLES) ? RESET_PULSE_CYCLES : DEBOUNCE_CYCLES) :
        ((TIMEOUT_CYCLES > DEBOUNCE_CYCLES) ? TIMEOUT_CYCLES : DEBOUNCE_CYCLES);
    localparam int TIMER_W = $clog2(MAX_CYCLES) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [TIMER_W-1:0] RESET_LAST    = TIMER_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DEBOUNCE_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT   = RETRY_W'(MAX_RETRY);

    gt_link_state_t        state;
    gt_link_state_t        state_next;
    logic [TIMER_W-1:0]    timer;
    logic [TIMER_W-1:0]    timer_next;
    logic [RETRY_W-1:0]    retry_next;
    logic [DROP_CNT_W-1:0] drop_next;
    logic                  all_good;

    // Inputs are already in this domain; combine them directly with no extra flops.
    assign all_good = tx_good_init_synced & (&rx_good_init_synced);

    // Next-state, counter updates and timer restart on any state change.
    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        drop_next  = drop_cnt;
        timer_next = timer;
        case (state)
            RESET_GT: begin
                if (timer == RESET_LAST) begin
                    state_next = WAIT_GOOD;
                end
            end
            WAIT_GOOD: begin
                // A good cycle on the timeout edge takes priority over the retry.
                if (all_good) begin
                    state_next = DEBOUNCE;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_next = retry_cnt + 1'b1;
                    state_next = (retry_next == RETRY_LIMIT) ? FAIL : RESET_GT;
                end
            end
            DEBOUNCE: begin
                if (!all_good) begin
                    state_next = WAIT_GOOD;
                end else if (timer == DEBOUNCE_LAST) begin
                    state_next = UP;
                    retry_next = '0;
                end
            end
            UP: begin
                // No debounce on the way down: any bad cycle re-resets the GT.
                if (!all_good) begin
                    state_next = RESET_GT;
                    if (drop_cnt != {DROP_CNT_W{1'b1}}) begin
                        drop_next = drop_cnt + 1'b1;
                    end
                end
            end
            FAIL: begin
                state_next = FAIL;
            end
            default: begin
                state_next = RESET_GT;
            end
        endcase

        if (state_next != state) begin
            timer_next = '0;
        end else if (state == RESET_GT || state == WAIT_GOOD || state == DEBOUNCE) begin
            timer_next = timer + 1'b1;
        end
    end

    // State, timer and counters; outputs decode the next state so they move with it.
    always_ff @(posedge init_clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_GT;
            timer     <= '0;
            retry_cnt <= '0;
            drop_cnt  <= '0;
            gt_reset  <= 1'b1;
            link_up   <= 1'b0;
            link_fail <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            retry_cnt <= retry_next;
            if (drop_next != drop_cnt) begin
                drop_cnt <= drop_next;
            end
            gt_reset  <= (state_next == RESET_GT);
            link_up   <= (state_next == UP);
            link_fail <= (state_next == FAIL);
        end
    end

endmodule
